// File: rtl/gray_wptr_full.sv
// Write-side pointer and full-flag controller for the async FIFO (write clock domain).
// Exports a registered Gray write pointer and derives full/level/almost_full from the synchronised read pointer.
module gray_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rq_gptr,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wq_gptr,
    output logic [ADDR_WIDTH:0]   rptr_sync,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  almost_full
);

    localparam int PW = ADDR_WIDTH + 1;
    // Full when the write pointer is one lap ahead: the two Gray MSBs differ, the rest match.
    localparam logic [PW-1:0] FULL_MASK = PW'(2'b11) << (PW - 2);
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wgray_r;
    logic [PW-1:0] sync_r [SYNC_STAGES];
    logic          full_r;

    logic          wr_ack_s;
    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] wgray_next_s;
    logic          full_next_s;
    logic [PW-1:0] rbin_sync_s;
    logic [PW-1:0] level_s;

    // Next-pointer and full-flag computation from the pre-edge state.
    always_comb begin
        wr_ack_s     = wr_en & ~full_r;
        wbin_next_s  = wbin_r;
        wgray_next_s = wgray_r;
        if (wr_ack_s) begin
            wbin_next_s  = wbin_r + PW'(1);
            wgray_next_s = b2g(wbin_r + PW'(1));
        end else begin
            wbin_next_s  = wbin_r;
            wgray_next_s = wgray_r;
        end
        full_next_s = (wgray_next_s == (sync_r[SYNC_STAGES-1] ^ FULL_MASK));
        rbin_sync_s = g2b(sync_r[SYNC_STAGES-1]);
        level_s     = wbin_r - rbin_sync_s;
    end

    // Write pointer (binary and Gray copies) and full flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbin_r  <= '0;
            wgray_r <= '0;
            full_r  <= 1'b0;
        end else begin
            wbin_r  <= wbin_next_s;
            wgray_r <= wgray_next_s;
            full_r  <= full_next_s;
        end
    end

    // Plain flop chain for the incoming Gray read pointer; no logic between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= rq_gptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign wr_ack      = wr_ack_s;
    assign waddr       = wbin_r[ADDR_WIDTH-1:0];
    assign wq_gptr     = wgray_r;
    assign rptr_sync   = sync_r[SYNC_STAGES-1];
    assign level       = level_s;
    assign full        = full_r;
    assign almost_full = (level_s >= AFULL_LVL);

endmodule

// File: tb/tb_gray_wptr_full.sv
// Self-checking bench for gray_wptr_full (ADDR_WIDTH=2, SYNC_STAGES=2, AFULL_THRESH=3).
// A write-count/read-history model is compared every cycle, plus directed literal checks.
module tb_gray_wptr_full;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       wr_en;
    logic [2:0] rq_gptr;
    logic       wr_ack;
    logic [1:0] waddr;
    logic [2:0] wq_gptr;
    logic [2:0] rptr_sync;
    logic [2:0] level;
    logic       full;
    logic       almost_full;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    gray_wptr_full #(
        .ADDR_WIDTH  (2),
        .SYNC_STAGES (2),
        .AFULL_THRESH(3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rq_gptr    (rq_gptr),
        .wr_ack     (wr_ack),
        .waddr      (waddr),
        .wq_gptr    (wq_gptr),
        .rptr_sync  (rptr_sync),
        .level      (level),
        .full       (full),
        .almost_full(almost_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 if (clk_en) clk = ~clk;
    end

    function automatic int gray2bin(input int g);
        int b;
        b = g;
        for (int s = 1; s < 3; s++) b = b ^ (g >> s);
        return b & 7;
    endfunction

    function automatic int bin2gray(input int v);
        return (v ^ (v >> 1)) & 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: number of accepted writes mod 8, last two sampled read pointers, full flag.
    int       m_wcnt;
    bit [2:0] m_hist [2];
    bit       m_full;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wcnt    <= 0;
            m_hist[0] <= 3'd0;
            m_hist[1] <= 3'd0;
            m_full    <= 1'b0;
        end else begin
            automatic int acc = (wr_en && !m_full) ? 1 : 0;
            automatic int nw  = (m_wcnt + acc) % 8;
            automatic int rb  = gray2bin(int'(m_hist[1]));
            m_wcnt    <= nw;
            m_hist[0] <= rq_gptr;
            m_hist[1] <= m_hist[0];
            m_full    <= (((nw - rb + 8) % 8) == 4);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on && !rst) begin
            automatic int lvl = (m_wcnt - gray2bin(int'(m_hist[1])) + 8) % 8;
            chk("cyc_waddr", 32'(waddr), 32'(m_wcnt % 4));
            chk("cyc_wq_gptr", 32'(wq_gptr), 32'(bin2gray(m_wcnt)));
            chk("cyc_rptr_sync", 32'(rptr_sync), 32'(m_hist[1]));
            chk("cyc_level", 32'(level), 32'(lvl));
            chk("cyc_full", 32'(full), 32'(m_full));
            chk("cyc_almost_full", 32'(almost_full), 32'(lvl >= 3));
            chk("cyc_wr_ack", 32'(wr_ack), 32'(wr_en && !m_full));
            chk("cyc_full_at_depth", 32'(level == 3'd4 && !full), 32'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rq_gptr = 3'd0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        automatic int exp_fill [4] = '{1, 3, 2, 6};
        clk_en  = 1'b0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rq_gptr = 3'd0;

        // Reset with the clock stopped.
        #3 rst = 1'b1;
        #1;
        chk("rst_waddr", 32'(waddr), 32'(0));
        chk("rst_wq_gptr", 32'(wq_gptr), 32'(0));
        chk("rst_rptr_sync", 32'(rptr_sync), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_almost_full", 32'(almost_full), 32'(0));
        chk("rst_wr_ack", 32'(wr_ack), 32'(0));
        #2 rst = 1'b0;
        clk_en = 1'b1;
        chk_on = 1'b1;
        repeat (5) tick();
        chk("idle_wq_gptr", 32'(wq_gptr), 32'(0));
        chk("idle_level", 32'(level), 32'(0));
        chk("idle_full", 32'(full), 32'(0));

        // Fill.
        rq_gptr = 3'd0;
        wr_en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fill_waddr", 32'(waddr), 32'(i));
            chk("fill_ack", 32'(wr_ack), 32'(1));
            tick();
            chk("fill_wq_gptr", 32'(wq_gptr), 32'(exp_fill[i]));
        end
        chk("fill_full", 32'(full), 32'(1));
        chk("fill_level", 32'(level), 32'(4));
        #1;
        chk("over_ack", 32'(wr_ack), 32'(0));
        tick();
        chk("over_wq_gptr", 32'(wq_gptr), 32'(6));
        chk("over_waddr", 32'(waddr), 32'(0));

        // Drain visibility.
        wr_en   = 1'b0;
        rq_gptr = 3'b011;
        tick();
        chk("drain1_rptr_sync", 32'(rptr_sync), 32'(0));
        chk("drain1_full", 32'(full), 32'(1));
        tick();
        chk("drain2_rptr_sync", 32'(rptr_sync), 32'(3));
        chk("drain2_level", 32'(level), 32'(2));
        chk("drain2_full", 32'(full), 32'(1));
        tick();
        chk("drain3_full", 32'(full), 32'(0));
        wr_en = 1'b1;
        #1;
        chk("drain_ack", 32'(wr_ack), 32'(1));
        tick();
        chk("drain_wq_gptr", 32'(wq_gptr), 32'(7));
        chk("drain_level", 32'(level), 32'(3));
        wr_en = 1'b0;

        // Wrap with the read pointer trailing.
        pulse_rst();
        for (int k = 0; k < 12; k++) begin
            wr_en   = 1'b1;
            rq_gptr = 3'(bin2gray(k % 8));
            tick();
            chk("wrap_full", 32'(full), 32'(0));
            if (k == 3) chk("wrap_waddr0", 32'(waddr), 32'(0));
            if (k == 6) chk("wrap_wq_100", 32'(wq_gptr), 32'(4));
            if (k == 7) chk("wrap_wq_000", 32'(wq_gptr), 32'(0));
        end
        wr_en = 1'b0;

        // almost_full.
        pulse_rst();
        wr_en = 1'b1;
        repeat (3) tick();
        wr_en = 1'b0;
        #1;
        chk("af_level", 32'(level), 32'(3));
        chk("af_almost_full", 32'(almost_full), 32'(1));
        chk("af_full", 32'(full), 32'(0));
        wr_en = 1'b1;
        tick();
        chk("af_full_after", 32'(full), 32'(1));
        chk("af_level_after", 32'(level), 32'(4));
        wr_en = 1'b0;

        // Async reset mid-fill.
        pulse_rst();
        wr_en = 1'b1;
        tick();
        tick();
        wr_en = 1'b0;
        chk("mid_waddr_pre", 32'(waddr), 32'(2));
        #1 rst = 1'b1;
        #1;
        chk("mid_waddr", 32'(waddr), 32'(0));
        chk("mid_wq_gptr", 32'(wq_gptr), 32'(0));
        chk("mid_level", 32'(level), 32'(0));
        rst   = 1'b0;
        wr_en = 1'b1;
        #1;
        chk("mid_next_waddr", 32'(waddr), 32'(0));
        chk("mid_next_ack", 32'(wr_ack), 32'(1));
        tick();
        chk("mid_next_wq", 32'(wq_gptr), 32'(1));
        wr_en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
